restoring_divider_8_bit: RTL and testbench

- Multi-cycle unsigned integer divider. It is the inverse-operation companion to the combinational 8-bit add/sub datapath.
- It performs one shift plus one trial subtraction per clock and takes WIDTH iterations per operation.
- A single-cycle start/done handshake connects it to a controlling FSM or testbench.
- The quotient and remainder stay registered until the next accepted start.

---
 rtl/restoring_divider_8_bit.sv | 126 ++++++++++++
 tb/tb_restoring_divider_8_bit.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/restoring_divider_8_bit.sv
// rtl/restoring_divider_8_bit.sv - multi-cycle unsigned restoring divider
//
// Purpose: unsigned integer divider that performs one shift and one trial
// subtraction per clock. An operation takes WIDTH clock edges after the
// accepting start edge. A zero divisor completes on the accepting edge.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous, active-high reset
//   start        request pulse, sampled only while idle
//   dividend     unsigned dividend, captured on the accepted start edge
//   divisor      unsigned divisor, captured on the accepted start edge
//   busy         high while an operation is in progress
//   done         one-cycle pulse; results are valid from this cycle
//   quotient     registered quotient (all ones on divide by zero)
//   remainder    registered remainder (dividend on divide by zero)
//   div_by_zero  registered flag, set when the captured divisor was 0
module restoring_divider_8_bit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic {
    IDLE,
    CALC
  } state_t;

  state_t           state;
  state_t           state_n;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem_w;
  logic [WIDTH-1:0] q_w;
  logic [WIDTH-1:0] div_r;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             fits;
  logic [WIDTH-1:0] rem_n;
  logic [WIDTH-1:0] q_n;
  logic             last_iter;

  // The partial remainder is always below the divisor, so its WIDTH+1-bit
  // value never sets the top bit; only the low WIDTH bits are stored.
  always_comb begin
    shifted   = {rem_w, q_w[WIDTH-1]};
    trial     = shifted - {1'b0, div_r};
    fits      = ~trial[WIDTH];
    rem_n     = fits ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    q_n       = {q_w[WIDTH-2:0], fits};
    last_iter = (cnt == CW'(WIDTH - 1));
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start && (divisor != '0)) state_n = CALC;
      CALC:    if (last_iter) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  assign busy = (state == CALC);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      cnt         <= '0;
      rem_w       <= '0;
      q_w         <= '0;
      div_r       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (divisor != '0) begin
              rem_w <= '0;
              q_w   <= dividend;
              div_r <= divisor;
              cnt   <= '0;
            end else begin
              // Divide by zero finishes immediately without entering CALC.
              done        <= 1'b1;
              div_by_zero <= 1'b1;
              quotient    <= '1;
              remainder   <= dividend;
            end
          end
        end
        CALC: begin
          rem_w <= rem_n;
          q_w   <= q_n;
          cnt   <= cnt + CW'(1);
          if (last_iter) begin
            quotient    <= q_n;
            remainder   <= rem_n;
            div_by_zero <= 1'b0;
            done        <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_restoring_divider_8_bit.sv
// tb/tb_restoring_divider_8_bit.sv - scoreboard bench for restoring_divider_8_bit
module tb_restoring_divider_8_bit;

  typedef struct {
    int a;
    int b;
    int q;
    int r;
    int dbz;
    int cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] dividend = '0;
  logic [7:0] divisor = '0;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       div_by_zero;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  exp_t sb[$];

  restoring_divider_8_bit #(.WIDTH(8)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .dividend(dividend),
    .divisor(divisor),
    .busy(busy),
    .done(done),
    .quotient(quotient),
    .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse is matched against the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("quotient", int'(quotient), e.q);
        chk("remainder", int'(remainder), e.r);
        chk("div_by_zero", int'(div_by_zero), e.dbz);
        chk("done_cycle", cyc, e.cyc);
        chk("busy_at_done", int'(busy), 0);
        if (e.b != 0) begin
          chk("invariant_sum", int'(quotient) * e.b + int'(remainder), e.a);
          chk("invariant_rem_lt_div", int'(int'(remainder) < e.b), 1);
        end
      end
    end
  end

  // Drives one request from the current time; the next rising edge accepts it.
  task automatic issue(input int a, input int b, input int q, input int r,
                       input int dbz, input int lat);
    exp_t e;
    dividend = 8'(a);
    divisor  = 8'(b);
    start    = 1'b1;
    e.a = a; e.b = b; e.q = q; e.r = r; e.dbz = dbz;
    e.cyc = cyc + 1 + lat;
    sb.push_back(e);
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_empty(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      chk(name, sb.size(), 0);
      sb.delete();
    end
  endtask

  initial begin
    int nb;
    int a;
    int b;

    #1;
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_quotient", int'(quotient), 0);
    chk("reset_remainder", int'(remainder), 0);
    chk("reset_dbz", int'(div_by_zero), 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;

    // 100 / 7: busy for exactly 8 cycles
    issue(100, 7, 14, 2, 0, 8);
    nb = 0;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      if (busy) nb++;
    end
    chk("busy_cycles_100_7", nb, 8);
    wait_empty("timeout_100_7");

    // 255 / 1 then 3 / 10 started in the done cycle
    @(posedge clk);
    #1 issue(255, 1, 255, 0, 0, 8);
    begin
      int n;
      n = 0;
      while (!done && n < 20) begin
        @(negedge clk);
        n++;
      end
      chk("done_seen_255_1", int'(done), 1);
    end
    issue(3, 10, 0, 3, 0, 8);
    wait_empty("timeout_3_10");

    // 5 / 0 completes on the accept edge, busy never rises
    @(posedge clk);
    #1 issue(5, 0, 255, 5, 1, 0);
    nb = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (busy) nb++;
    end
    chk("busy_cycles_div0", nb, 0);
    wait_empty("timeout_5_0");
    @(posedge clk);
    #1 issue(200, 200, 1, 0, 0, 8);
    wait_empty("timeout_200_200");

    // 200 / 3 with an ignored start and operand changes mid-operation
    @(posedge clk);
    #1 issue(200, 3, 66, 2, 0, 8);
    repeat (2) @(posedge clk);
    #1;
    start = 1'b1; dividend = 8'd9; divisor = 8'd9;
    @(posedge clk);
    #1;
    start = 1'b0; dividend = 8'd17; divisor = 8'd4;
    @(posedge clk);
    #1 divisor = 8'd0;
    wait_empty("timeout_200_3");
    repeat (10) @(negedge clk);

    // 77 / 5 aborted by an asynchronous reset in the 4th busy cycle
    @(posedge clk);
    #1 issue(77, 5, 15, 2, 0, 8);
    repeat (3) @(posedge clk);
    #3 reset = 1'b1;
    sb.delete();
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_quotient", int'(quotient), 0);
    chk("abort_remainder", int'(remainder), 0);
    chk("abort_dbz", int'(div_by_zero), 0);
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (12) @(negedge clk);
    #1 issue(77, 5, 15, 2, 0, 8);
    wait_empty("timeout_77_5");

    // Sweep: 1000 operand pairs back-to-back, expectations from / and %
    @(posedge clk);
    #1;
    for (int i = 0; i < 1000; i++) begin
      a = int'($urandom_range(0, 255));
      b = int'($urandom_range(1, 255));
      issue(a, b, a / b, a % b, 0, 8);
      wait_empty("timeout_sweep");
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
